// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
// Command engine behind the uart byte interface. Parses fixed-length frames
// (SYNC, CMD, ADDR, DATA[, CHK]), performs one local-bus write or read and
// returns ACK / ACK+data / NAK bytes through the uart transmit handshake.
//
// Build option: define UART_CMD_CHECKSUM_EN to include the CHK byte
// (CHK = CMD ^ ADDR ^ DATA, mismatch -> NAK). Without it frames are 4 bytes.
//
// Ports:
//   clock_50MHZ, reset            clock, synchronous active-high reset
//   rx_rdy, rx_dout, rx_rdy_clr   receive handshake (uart.rdy/dout/rdy_clr)
//   tx_din, tx_enable, tx_busy    transmit handshake (uart.din/enable/tx_busy)
//   mem_addr, mem_wdata, mem_we,  local bus; mem_rdata valid 1 cycle after
//   mem_re, mem_rdata             mem_re
//   frame_ok, frame_err           one-cycle frame outcome pulses
module uart_cmd_responder #(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter logic [7:0] ACK_BYTE       = 8'h55,
    parameter logic [7:0] NAK_BYTE       = 8'hEE
) (
    input  logic       clock_50MHZ,
    input  logic       reset,
    input  logic       rx_rdy,
    input  logic [7:0] rx_dout,
    output logic       rx_rdy_clr,
    output logic [7:0] tx_din,
    output logic       tx_enable,
    input  logic       tx_busy,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    input  logic [7:0] mem_rdata,
    output logic       frame_ok,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // frame_err is registered, so the decision is taken one cycle early and
    // the counter reads 0 in the cycle after a capture: the error pulse then
    // lands exactly TIMEOUT_CYCLES clocks after the last captured byte.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    typedef enum logic [3:0] {
        IDLE, GET_CMD, GET_ADDR, GET_DATA,
`ifdef UART_CMD_CHECKSUM_EN
        GET_CHK,
`endif
        EXEC, READ_WAIT, SEND, SEND_HI, SEND_LO
    } state_t;

`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t LAST_ST = GET_CHK;
`else
    localparam state_t LAST_ST = GET_DATA;
`endif

    state_t        state;
    logic [1:0]    hold;       // capture holdoff, blocks the two cycles after a capture
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    cmd_r, addr_r;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]    data_r;
`endif
    logic          is_rd;
    logic [7:0]    q0, q1;     // reply queue, q0 is the next byte out
    logic [1:0]    q_len;

    logic       rx_state, in_get, capture, frame_done, tmo_hit, fin_ok;
    logic [7:0] fin_data;

    always_comb begin
        in_get = (state == GET_CMD) || (state == GET_ADDR) || (state == GET_DATA);
`ifdef UART_CMD_CHECKSUM_EN
        in_get = in_get || (state == GET_CHK);
        fin_data = data_r;
        fin_ok   = ((cmd_r ^ addr_r ^ data_r) == rx_dout);
`else
        fin_data = rx_dout;
        fin_ok   = 1'b1;
`endif
        rx_state   = in_get || (state == IDLE);
        capture    = rx_rdy && rx_state && (hold == 2'd0);
        frame_done = capture && (state == LAST_ST);
        tmo_hit    = in_get && !capture && (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clock_50MHZ) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            tmo_cnt    <= '0;
            cmd_r      <= '0;
            addr_r     <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            data_r     <= '0;
`endif
            is_rd      <= 1'b0;
            q0         <= '0;
            q1         <= '0;
            q_len      <= '0;
            rx_rdy_clr <= 1'b0;
            tx_din     <= '0;
            tx_enable  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_rdy_clr <= capture;
            tx_enable  <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;

            if (capture)            hold <= 2'd2;
            else if (hold != 2'd0)  hold <= hold - 2'd1;

            if (capture || state == IDLE) tmo_cnt <= '0;
            else if (in_get)              tmo_cnt <= tmo_cnt + TW'(1);

            case (state)
                IDLE:     if (capture && rx_dout == SYNC_BYTE) state <= GET_CMD;
                GET_CMD:  if (capture) begin cmd_r  <= rx_dout; state <= GET_ADDR; end
                GET_ADDR: if (capture) begin addr_r <= rx_dout; state <= GET_DATA; end
`ifdef UART_CMD_CHECKSUM_EN
                GET_DATA: if (capture) begin data_r <= rx_dout; state <= GET_CHK; end
`endif
                EXEC:     state <= is_rd ? READ_WAIT : SEND;
                READ_WAIT: begin
                    q0       <= ACK_BYTE;
                    q1       <= mem_rdata;
                    q_len    <= 2'd2;
                    frame_ok <= 1'b1;
                    state    <= SEND;
                end
                SEND: if (!tx_busy) begin
                    tx_din    <= q0;
                    tx_enable <= 1'b1;
                    q0        <= q1;
                    q_len     <= q_len - 2'd1;
                    state     <= SEND_HI;
                end
                SEND_HI: if (tx_busy) state <= SEND_LO;
                SEND_LO: if (!tx_busy) state <= (q_len != 2'd0) ? SEND : IDLE;
                default: ;
            endcase

            // Last byte of the frame: outcome is decided here so the bus
            // strobe and result pulse are visible during EXEC.
            if (frame_done) begin
                state     <= EXEC;
                mem_addr  <= addr_r;
                mem_wdata <= fin_data;
                is_rd     <= 1'b0;
                if (!fin_ok || (cmd_r != CMD_WR && cmd_r != CMD_RD)) begin
                    q0        <= NAK_BYTE;
                    q_len     <= 2'd1;
                    frame_err <= 1'b1;
                end else if (cmd_r == CMD_WR) begin
                    mem_we   <= 1'b1;
                    q0       <= ACK_BYTE;
                    q_len    <= 2'd1;
                    frame_ok <= 1'b1;
                end else begin
                    mem_re <= 1'b1;
                    is_rd  <= 1'b1;
                end
            end

            if (tmo_hit) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized self-checking bench for uart_cmd_responder. A frame-level model
// predicts bus activity, result pulses and reply bytes; bench-side uart and
// memory models stand in for the neighbouring blocks.
module tb_uart_cmd_responder;
    localparam int TMO = 200;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_rdy;
    logic [7:0] rx_dout;
    logic       rx_rdy_clr;
    logic [7:0] tx_din;
    logic       tx_enable;
    logic       tx_busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, mem_re, frame_ok, frame_err;

    uart_cmd_responder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock_50MHZ(clk), .reset(reset),
        .rx_rdy(rx_rdy), .rx_dout(rx_dout), .rx_rdy_clr(rx_rdy_clr),
        .tx_din(tx_din), .tx_enable(tx_enable), .tx_busy(tx_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // ---------------- environment monitors / models ----------------
    int         cyc = 0;
    int         cnt_clr = 0, cnt_we = 0, cnt_re = 0, cnt_ok = 0, cnt_err = 0;
    int         last_clr_cyc = 0, err_cyc = 0;
    int         overlap = 0, en_viol = 0, din_viol = 0;
    logic [7:0] we_addr = 0, we_data = 0;
    logic [7:0] slave_mem [256];
    logic [7:0] txq [$];

    initial begin
        int busy_left;
        bit rd_hold;
        logic [7:0] held_din;
        busy_left = 0;
        rd_hold   = 1'b0;
        held_din  = 8'h00;
        tx_busy   = 1'b0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i * 37 + 11);
        forever begin
            @(negedge clk);
            cyc++;
            if (rx_rdy_clr) begin cnt_clr++; last_clr_cyc = cyc; end
            if (mem_we) begin
                cnt_we++;
                slave_mem[mem_addr] = mem_wdata;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            if (frame_ok) cnt_ok++;
            if (frame_err) begin cnt_err++; err_cyc = cyc; end
            if (frame_ok && frame_err) overlap++;
            // read data valid only around the cycle after mem_re
            if (rd_hold) rd_hold = 1'b0;
            else if (mem_re) begin mem_rdata = slave_mem[mem_addr]; rd_hold = 1'b1; end
            else mem_rdata = 8'($urandom);
            // transmitter: busy for a random stretch after each enable
            if (busy_left > 0 && tx_din !== held_din) din_viol++;
            if (tx_enable) begin
                if (tx_busy) en_viol++;
                txq.push_back(tx_din);
                held_din  = tx_din;
                busy_left = $urandom_range(2, 9);
                tx_busy   = 1'b1;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
        end
    end

    // ---------------- reference model (frame level) ----------------
    logic [7:0] model_mem [256];
    logic [7:0] gq [$];    // garbage bytes sent ahead of the next frame

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        rx_dout = b;
        rx_rdy  = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!rx_rdy_clr && t < 100);
        check("rx_consumed", rx_rdy_clr, 1'b1);
        rx_rdy = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] data, input bit corrupt);
        int clr0, we0, re0, ok0, err0, ng, t;
        int e_we, e_re, e_ok, e_err;
        logic [7:0] exp_q [$];
        logic [7:0] chk;
        bit bad;
        clr0 = cnt_clr; we0 = cnt_we; re0 = cnt_re; ok0 = cnt_ok; err0 = cnt_err;
        txq.delete();
        e_we = 0; e_re = 0; e_ok = 0; e_err = 0;
        bad = corrupt || !(cmd == 8'h01 || cmd == 8'h02);
        if (bad) begin
            exp_q.push_back(8'hEE); e_err = 1;
        end else if (cmd == 8'h01) begin
            model_mem[addr] = data;
            exp_q.push_back(8'h55); e_we = 1; e_ok = 1;
        end else begin
            exp_q.push_back(8'h55); exp_q.push_back(model_mem[addr]); e_re = 1; e_ok = 1;
        end
        ng = gq.size();
        while (gq.size() > 0) send_byte(gq.pop_front());
        send_byte(8'hAA);
        send_byte(cmd);
        send_byte(addr);
        send_byte(data);
`ifdef UART_CMD_CHECKSUM_EN
        chk = cmd ^ addr ^ data;
        if (corrupt) chk = chk ^ (8'h01 << $urandom_range(0, 7));
        send_byte(chk);
`else
        chk = 8'h00;
`endif
        t = 0;
        while ((txq.size() < exp_q.size() || tx_busy) && t < 2000) begin @(negedge clk); t++; end
        repeat (6) @(negedge clk);
        check({tag, ":clr"}, 64'(cnt_clr - clr0), 64'(ng + FLEN));
        check({tag, ":we"},  64'(cnt_we - we0),   64'(e_we));
        check({tag, ":re"},  64'(cnt_re - re0),   64'(e_re));
        check({tag, ":ok"},  64'(cnt_ok - ok0),   64'(e_ok));
        check({tag, ":err"}, 64'(cnt_err - err0), 64'(e_err));
        check({tag, ":nrep"}, 64'(txq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, ":rep"}, (i < txq.size()) ? 64'(txq[i]) : 64'hXX, 64'(exp_q[i]));
        if (e_we != 0) begin
            check({tag, ":waddr"}, 64'(we_addr), 64'(addr));
            check({tag, ":wdata"}, 64'(we_data), 64'(data));
        end
    endtask

    // mem_re is counted here so the monitor process stays simple
    always @(negedge clk) if (mem_re) cnt_re <= cnt_re + 1;

    function automatic logic [47:0] outs();
        return {rx_rdy_clr, tx_din, tx_enable, mem_addr, mem_wdata, mem_we, mem_re,
                frame_ok, frame_err};
    endfunction

    initial begin
        int clr0, we0, ok0, err0, kc, t, r;
        logic [7:0] c, a, d;
        reset = 1'b1; rx_rdy = 1'b0; rx_dout = 8'h00;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'(i * 37 + 11);
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 48'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("wr10", 8'h01, 8'h10, 8'h3C, 1'b0);
        run_frame("rd10", 8'h02, 8'h10, 8'h00, 1'b0);
`ifdef UART_CMD_CHECKSUM_EN
        run_frame("badchk", 8'h01, 8'h10, 8'h77, 1'b1);
`endif
        run_frame("badcmd", 8'h07, 8'h20, 8'h11, 1'b0);
        gq.push_back(8'h00); gq.push_back(8'hFF); gq.push_back(8'h13);
        run_frame("garbage", 8'h01, 8'h21, 8'h5A, 1'b0);
        run_frame("rd21", 8'h02, 8'h21, 8'hAA, 1'b0);

        // timeout after CMD: error exactly TMO clocks after the capture
        clr0 = cnt_clr; err0 = cnt_err; txq.delete();
        send_byte(8'hAA);
        send_byte(8'h01);
        kc = last_clr_cyc;
        t = 0;
        while (cnt_err == err0 && t < TMO + 50) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        check("tmo:err", 64'(cnt_err - err0), 64'd1);
        check("tmo:lat", 64'(err_cyc - kc), 64'(TMO - 1));
        check("tmo:nrep", 64'(txq.size()), 64'd0);
        check("tmo:clr", 64'(cnt_clr - clr0), 64'd2);
        run_frame("after_tmo", 8'h01, 8'h30, 8'hC3, 1'b0);

        // reset after ADDR: frame dropped, trailing bytes seen as garbage
        clr0 = cnt_clr; we0 = cnt_we; ok0 = cnt_ok; err0 = cnt_err; txq.delete();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h10);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid:outs", outs(), 48'h0);
        reset = 1'b0;
        send_byte(8'h3C);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h2D);
`endif
        repeat (20) @(negedge clk);
        check("rst_mid:we", 64'(cnt_we - we0), 64'd0);
        check("rst_mid:ok", 64'(cnt_ok - ok0), 64'd0);
        check("rst_mid:err", 64'(cnt_err - err0), 64'd0);
        check("rst_mid:nrep", 64'(txq.size()), 64'd0);
        check("rst_mid:clr", 64'(cnt_clr - clr0), 64'(FLEN));
        run_frame("after_rst", 8'h02, 8'h10, 8'h00, 1'b0);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            if (r < 4) c = 8'h01;
            else if (r < 8) c = 8'h02;
            else begin
                c = 8'($urandom);
                if (c == 8'h01 || c == 8'h02) c = 8'h80;
            end
            if ($urandom_range(0, 3) == 0)
                for (int g = 0; g < $urandom_range(1, 3); g++) begin
                    d = 8'($urandom);
                    gq.push_back((d == 8'hAA) ? 8'h00 : d);
                end
            d = 8'($urandom);
`ifdef UART_CMD_CHECKSUM_EN
            run_frame("rand", c, a, d, r == 9);
`else
            run_frame("rand", c, a, d, 1'b0);
`endif
        end

        check("ok_err_overlap", 64'(overlap), 64'd0);
        check("tx_en_while_busy", 64'(en_viol), 64'd0);
        check("tx_din_stable", 64'(din_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Host-side command engine on the far end of the `uart` byte interface. It consumes received bytes through the `rdy`/`rdy_clr`/`dout` handshake and parses fixed-length command frames. It executes register writes and reads on a simple local bus, then returns the reply bytes through the `din`/`enable`/`tx_busy` transmit handshake. It sits between the `uart` wrapper and the register/memory block on the FPGA.

## Interface
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte timeout in clocks (20 ms at 50 MHz); counter width `$clog2(TIMEOUT_CYCLES+1)`.
- `SYNC_BYTE`, 8'hAA: frame start marker.
- `ACK_BYTE`, 8'h55: success reply.
- `NAK_BYTE`, 8'hEE: failure reply.

Ports:
- `clock_50MHZ` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_rdy` in 1: received byte valid (from `uart.rdy`).
- `rx_dout` in 8: received byte (from `uart.dout`).
- `rx_rdy_clr` out 1: one-cycle pulse that consumes the byte (to `uart.rdy_clr`).
- `tx_din` out 8: byte to transmit (to `uart.din`).
- `tx_enable` out 1: one-cycle transmit request (to `uart.enable`).
- `tx_busy` in 1: transmitter busy (from `uart.tx_busy`).
- `mem_addr` out 8: bus address.
- `mem_wdata` out 8: bus write data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_re` out 1: one-cycle read strobe.
- `mem_rdata` in 8: read data, valid exactly 1 cycle after `mem_re`.
- `frame_ok` out 1: one-cycle pulse when a frame executes.
- `frame_err` out 1: one-cycle pulse on bad checksum, unknown CMD, or timeout.

## Operation
- Frame format: SYNC, CMD, ADDR, DATA, CHK, with CHK = CMD ^ ADDR ^ DATA.
  - CMD 8'h01 = write: DATA is written to ADDR.
  - CMD 8'h02 = read: DATA is don't-care but still included in CHK.
- Byte capture:
  - A byte is captured in cycle C when `rx_rdy`=1, the FSM is in a receive state, and no holdoff is active.
  - `rx_dout` is latched in C.
  - `rx_rdy_clr`=1 in C+1 only.
  - Capture is blocked in C+1 and C+2 (2-cycle holdoff, so the same byte is never taken twice).
- States:
  - `IDLE`: every byte is captured. SYNC_BYTE → `GET_CMD`; any other byte is discarded and the FSM stays in `IDLE`.
  - `GET_CMD` → `GET_ADDR` → `GET_DATA` → `GET_CHK` → `EXEC`, advancing one state per captured byte.
  - `EXEC`:
    - Checksum bad or CMD unknown: reply NAK, pulse `frame_err`.
    - Write: pulse `mem_we` with `mem_addr`/`mem_wdata`, queue ACK, pulse `frame_ok`.
    - Read: pulse `mem_re`, go to `READ_WAIT`.
  - `READ_WAIT`: latch `mem_rdata`, queue ACK then the data byte, pulse `frame_ok`.
  - `SEND`: when `tx_busy`=0, drive `tx_din` and pulse `tx_enable` for 1 cycle → `SEND_HI`.
  - `SEND_HI`: wait for `tx_busy`=1 → `SEND_LO`.
  - `SEND_LO`: wait for `tx_busy`=0. If reply bytes remain → `SEND`, else → `IDLE`.
- Timeout:
  - The counter clears on every capture and in `IDLE`.
  - In `GET_*`, when the counter reaches `TIMEOUT_CYCLES`: pulse `frame_err`, return to `IDLE`, send no reply.
- A SYNC_BYTE received mid-frame is treated as ordinary data; there is no resync.
- Bytes arriving during `EXEC`…`SEND_LO` are not consumed (`rx_rdy_clr` stays low). They are taken in `IDLE` and treated as a possible SYNC.

## Timing
- Reset values:
  - Every output is 0: `rx_rdy_clr`, `tx_din`, `tx_enable`, `mem_*`, `frame_ok`, `frame_err`.
  - State is `IDLE`; timeout counter, holdoff, and reply queue are cleared.
- Reset mid-frame or mid-reply aborts immediately. No `mem_we` is issued, and a reply byte already handed to `uart` is not recalled.
- Last byte (CHK) captured in cycle N, then `EXEC` in N+1:
  - Write: `mem_we` in N+1, `tx_enable` no earlier than N+2.
  - Read: `mem_re` in N+1, `mem_rdata` sampled in N+2, `tx_enable` no earlier than N+3.
- `mem_addr`/`mem_wdata` hold their values from `EXEC` until the next frame's `EXEC`.
- `tx_din` is stable from the `tx_enable` cycle until `SEND_LO` exits.
- `frame_ok`/`frame_err` never assert in the same cycle.

## Configuration
- `UART_CMD_CHECKSUM_EN`:
  - Defined: 5-byte frame with the CHK byte; mismatch → NAK and `frame_err`.
  - Undefined: 4-byte frame (SYNC, CMD, ADDR, DATA). `GET_CHK` is removed, `GET_DATA` goes directly to `EXEC`, and no checksum NAK exists (unknown CMD still NAKs).

## Test plan
- Write frame AA 01 10 3C 2D → `mem_we` once with `mem_addr`=8'h10 and `mem_wdata`=8'h3C; reply 55; `frame_ok` once.
- Preload addr 8'h10 = 8'h3C, then send AA 02 10 00 12 → `mem_re` once; reply 55 then 3C, each `tx_enable` only while `tx_busy`=0.
- AA 01 10 3C 00 (bad CHK) → no `mem_we`; reply EE; `frame_err` once.
- Garbage 00 FF 13, then a valid write frame → garbage consumed (3 `rx_rdy_clr` pulses); write executes normally.
- AA 01 followed by silence → `frame_err` exactly `TIMEOUT_CYCLES` clocks after the CMD capture; no reply; next valid frame accepted.
- `reset` asserted after the ADDR byte, then the remaining bytes sent → no `mem_we`, no reply, all outputs 0 in the cycle after reset.
